instruction_fetch: RTL and testbench

Instruction fetch stage of the 32-bit MIPS CPU, directly upstream of `control_unit`. It holds the program counter, issues word reads to instruction memory over a req/ready handshake, and presents the fetched word on `inst` with a valid flag. The next PC is computed from the control unit's `PCen`/`PCSrc` decisions: sequential, branch-relative or jump-absolute.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/instruction_fetch_if.sv | 15 +
 rtl/instruction_fetch_next_pc.sv | 32 +++
 rtl/instruction_fetch.sv | 86 ++++++++
 tb/tb_instruction_fetch.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS CPU definitions: datapath width, opcode constants, fetch FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int SIZE = 32;

  // Opcode / funct constants used by the decode side of the pipeline.
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetchState_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read channel between the fetch stage (master) and memory (slave).
// Latency: n/a (wires only).
// Backpressure: memory stalls the fetch by holding imem_ready low while imem_req is high.
// Ports: imem_req/imem_addr from fetch; imem_ready/imem_rdata from memory.
interface instruction_fetch_if #(
  parameter int SIZE = mips_pkg::SIZE
);
  logic            imem_req;
  logic [SIZE-1:0] imem_addr;
  logic            imem_ready;
  logic [SIZE-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_next_pc.sv
// Next-PC selection: jump-absolute beats branch-relative beats sequential.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is loaded.
// Ports: pc, branch_imm, jump_target, PCSrc, jump in; nextPc, pc_plus4 out.
module next_pc
  import mips_pkg::*;
#(
  parameter int SIZE = mips_pkg::SIZE
) (
  input  logic [SIZE-1:0] pc,
  input  logic [15:0]     branch_imm,
  input  logic [25:0]     jump_target,
  input  logic            PCSrc,
  input  logic            jump,
  output logic [SIZE-1:0] nextPc,
  output logic [SIZE-1:0] pc_plus4
);
  logic [SIZE-1:0] branchOff;
  logic [SIZE-1:0] jumpAddr;

  // Adds wrap modulo 2^SIZE naturally, which also covers negative offsets.
  assign pc_plus4  = pc + SIZE'(4);
  assign branchOff = {{(SIZE-18){branch_imm[15]}}, branch_imm, 2'b00};
  // Jump keeps the 256 MB region of the delay-slot address, not of pc itself.
  assign jumpAddr  = {pc_plus4[SIZE-1:28], jump_target, 2'b00};

  always_comb begin
    nextPc = pc_plus4;
    if (jump)       nextPc = jumpAddr;
    else if (PCSrc) nextPc = pc_plus4 + branchOff;
  end
endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: holds the PC, reads instruction memory, presents the word until retired.
// Latency: instruction valid 1 cycle after imem_req rises with zero-wait memory, +1 per wait cycle.
// Backpressure: waits in REQ for imem_ready; holds inst until control_unit pulses PCen.
// Ports: clk/rst; PCen/PCSrc/jump/branch_imm/jump_target from control; imem (master); inst, inst_valid, pc, pc_plus4 out.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int              SIZE     = mips_pkg::SIZE,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCen,
  input  logic                PCSrc,
  input  logic                jump,
  input  logic [15:0]         branch_imm,
  input  logic [25:0]         jump_target,
  instruction_fetch_if.master imem,
  output logic [SIZE-1:0]     inst,
  output logic                inst_valid,
  output logic [SIZE-1:0]     pc,
  output logic [SIZE-1:0]     pc_plus4
);
  fetchState_t     state, stateNext;
  logic [SIZE-1:0] nextPcVal;
  logic [SIZE-1:0] pcNext;
  logic [SIZE-1:0] instNext;
  logic            validNext;
  logic            reqQ;

  next_pc #(.SIZE(SIZE)) uNextPc (
    .pc          (pc),
    .branch_imm  (branch_imm),
    .jump_target (jump_target),
    .PCSrc       (PCSrc),
    .jump        (jump),
    .nextPc      (nextPcVal),
    .pc_plus4    (pc_plus4)
  );

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instNext  = inst;
    validNext = inst_valid;
    case (state)
      FETCH_IDLE: stateNext = FETCH_REQ;
      FETCH_REQ: begin
        // PCen is deliberately not looked at here: only the memory response matters.
        if (imem.imem_ready) begin
          instNext  = imem.imem_rdata;
          validNext = 1'b1;
          stateNext = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (PCen) begin
          pcNext    = nextPcVal;
          validNext = 1'b0;
          stateNext = FETCH_REQ;
        end
      end
      default: stateNext = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH_IDLE;
      pc         <= {RESET_PC[SIZE-1:2], 2'b00};
      inst       <= '0;
      inst_valid <= 1'b0;
      reqQ       <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      inst       <= instNext;
      inst_valid <= validNext;
      // Registered request tracks the state being entered, so it drops on the accepting edge.
      reqQ       <= (stateNext == FETCH_REQ);
    end
  end

  assign imem.imem_req  = reqQ;
  assign imem.imem_addr = pc;
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, PCen, PCSrc, jump;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic [31:0] inst, pc, pc_plus4;
  logic        inst_valid;
  instruction_fetch_if #(.SIZE(32)) memBus ();

  logic        rst2, PCen2;
  logic [31:0] inst2, pc2, pc_plus4_2;
  logic        inst_valid2;
  instruction_fetch_if #(.SIZE(32)) memBus2 ();

  instruction_fetch #(.SIZE(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .PCen(PCen), .PCSrc(PCSrc), .jump(jump),
    .branch_imm(branch_imm), .jump_target(jump_target), .imem(memBus),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4)
  );

  instruction_fetch #(.SIZE(32), .RESET_PC(WRAP_PC)) dutWrap (
    .clk(clk), .rst(rst2), .PCen(PCen2), .PCSrc(1'b0), .jump(1'b0),
    .branch_imm(16'h0000), .jump_target(26'h0), .imem(memBus2),
    .inst(inst2), .inst_valid(inst_valid2), .pc(pc2), .pc_plus4(pc_plus4_2)
  );

  int checkCount = 0;
  int errCount   = 0;
  logic [31:0] expPc;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == RST_PC) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Architectural next-PC rule, plain arithmetic.
  function automatic logic [31:0] refNext(input logic [31:0] cur, input logic j, input logic s,
                                          input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] p4;
    int          off;
    p4 = cur + 32'd4;
    if (j) return (p4 & 32'hF000_0000) + (32'(tgt) * 32'd4);
    off = int'($signed(imm)) * 4;
    if (s) return p4 + 32'(off);
    return p4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT just raised into REQ; leaves it in HOLD.
  task automatic fetchAt(input int waits, input logic [31:0] addr);
    checkVal("req_up", 32'(memBus.imem_req), 32'd1);
    checkVal("req_addr", memBus.imem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      memBus.imem_ready = 1'b0;
      PCen = 1'($urandom_range(0, 1));  // must be ignored in REQ
      jump = 1'($urandom_range(0, 1));
      step();
      checkVal("wait_req", 32'(memBus.imem_req), 32'd1);
      checkVal("wait_addr", memBus.imem_addr, addr);
      checkVal("wait_valid", 32'(inst_valid), 32'd0);
    end
    memBus.imem_ready = 1'b1;
    memBus.imem_rdata = memWord(addr);
    PCen = 1'($urandom_range(0, 1));
    step();
    memBus.imem_ready = 1'b0;
    memBus.imem_rdata = $urandom;
    PCen = 1'b0;
    jump = 1'b0;
    checkVal("acc_valid", 32'(inst_valid), 32'd1);
    checkVal("acc_inst", inst, memWord(addr));
    checkVal("acc_req", 32'(memBus.imem_req), 32'd0);
    checkVal("acc_pc", pc, addr);
    checkVal("acc_pc4", pc_plus4, addr + 32'd4);
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      memBus.imem_ready = 1'($urandom_range(0, 1));  // ignored outside REQ
      step();
      memBus.imem_ready = 1'b0;
      checkVal("hold_inst", inst, memWord(addr));
      checkVal("hold_pc", pc, addr);
      checkVal("hold_req", 32'(memBus.imem_req), 32'd0);
    end
  endtask

  task automatic retire(input logic j, input logic s, input logic [15:0] imm, input logic [25:0] tgt);
    jump = j; PCSrc = s; branch_imm = imm; jump_target = tgt; PCen = 1'b1;
    step();
    PCen = 1'b0; jump = 1'b0; PCSrc = 1'b0;
    expPc = refNext(expPc, j, s, imm, tgt);
    checkVal("ret_valid", 32'(inst_valid), 32'd0);
    checkVal("ret_pc", pc, expPc);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; PCen = 1'b0; PCSrc = 1'b0; jump = 1'b0; PCen2 = 1'b0;
    branch_imm = '0; jump_target = '0;
    memBus.imem_ready = 1'b0;  memBus.imem_rdata = '0;
    memBus2.imem_ready = 1'b0; memBus2.imem_rdata = '0;
    step(); step();
    checkVal("rst_pc", pc, RST_PC);
    checkVal("rst_pc4", pc_plus4, RST_PC + 32'd4);
    checkVal("rst_inst", inst, 32'd0);
    checkVal("rst_valid", 32'(inst_valid), 32'd0);
    checkVal("rst_req", 32'(memBus.imem_req), 32'd0);
    rst = 1'b0; rst2 = 1'b0;
    step();
    expPc = RST_PC;
    fetchAt(0, expPc);

    // Sequential, branches back and forward, then jump overriding branch.
    retire(0, 0, 16'h0, 26'h0); fetchAt(0, expPc);
    retire(0, 0, 16'h0, 26'h0); fetchAt(1, expPc);
    retire(0, 0, 16'h0, 26'h0); fetchAt(0, expPc);
    checkVal("seq_third", expPc, pc);
    retire(0, 0, 16'h0, 26'h0); fetchAt(0, expPc);
    checkVal("at_0x10", pc, 32'h0040_0010);
    retire(0, 1, 16'hFFFC, 26'h0); fetchAt(0, expPc);
    checkVal("br_back", pc, 32'h0040_0004);
    retire(0, 1, 16'h0002, 26'h0); fetchAt(0, expPc);
    retire(0, 1, 16'h0003, 26'h0); fetchAt(3, expPc);
    checkVal("br_fwd", pc, 32'h0040_0020);
    retire(0, 1, 16'hFFFB, 26'h0); fetchAt(0, expPc);
    retire(1, 1, 16'h0003, 26'h010_0008); fetchAt(2, expPc);
    checkVal("jump_wins", pc, 32'h0040_0020);

    // Reset in the middle of a request; a response during reset is dropped.
    retire(0, 0, 16'h0, 26'h0);
    rst = 1'b1;
    #1;
    checkVal("mid_req", 32'(memBus.imem_req), 32'd0);
    checkVal("mid_pc", pc, RST_PC);
    checkVal("mid_inst", inst, 32'd0);
    checkVal("mid_valid", 32'(inst_valid), 32'd0);
    memBus.imem_ready = 1'b1; memBus.imem_rdata = 32'hDEAD_BEEF;
    step();
    checkVal("rstresp_inst", inst, 32'd0);
    checkVal("rstresp_valid", 32'(inst_valid), 32'd0);
    memBus.imem_ready = 1'b0;
    rst = 1'b0;
    step();
    expPc = RST_PC;
    fetchAt(0, expPc);

    // Randomized program flow.
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0)      retire(0, 0, 16'($urandom), 26'($urandom));
      else if (kind == 3) retire(1, 1'($urandom_range(0, 1)), 16'($urandom), 26'($urandom));
      else                retire(0, 1, 16'($urandom), 26'($urandom));
      fetchAt(int'($urandom_range(0, 3)), expPc);
    end

    // Address wrap on the second instance.
    checkVal("wrap_req", 32'(memBus2.imem_req), 32'd1);
    checkVal("wrap_addr", memBus2.imem_addr, WRAP_PC);
    memBus2.imem_ready = 1'b1; memBus2.imem_rdata = 32'h0800_0000;
    step();
    memBus2.imem_ready = 1'b0;
    checkVal("wrap_inst", inst2, 32'h0800_0000);
    checkVal("wrap_valid", 32'(inst_valid2), 32'd1);
    checkVal("wrap_pc4", pc_plus4_2, refNext(WRAP_PC, 0, 0, 16'h0, 26'h0));
    PCen2 = 1'b1;
    step();
    PCen2 = 1'b0;
    checkVal("wrap_pc", pc2, 32'd0);
    checkVal("wrap_addr0", memBus2.imem_addr, 32'd0);
    checkVal("wrap_req2", 32'(memBus2.imem_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end
endmodule
